motor_cmd_decoder: RTL and testbench

//  Consumes each deserialized 32-bit frame (8-bit CMD + 24-bit DATA + done strobe) from the serial-in stage.

---
 rtl/motor_cmd_decoder.sv | 166 ++++++++++++++++
 tb/tb_motor_cmd_decoder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_decoder.sv
// -----------------------------------------------------------------------------
// motor_cmd_decoder
//   Turns each deserialized 32-bit frame (8-bit command + 24-bit payload) into
//   motor-control register writes, one-cycle control pulses and read-back
//   responses that go out to the serial-out stage over valid/ready.
//
// Ports
//   sys_clk     system clock, rising edge
//   rst         synchronous, active-high reset
//   cmd_done    frame-ready level from the deserializer (rising edge = frame)
//   cmd, data   command byte / 24-bit payload, valid while cmd_done is high
//   pos_count   live position count from the quadrature counter
//   resp_ready  serial-out stage accepts resp_word
//   speed_sp    speed setpoint             dir        direction (1 = forward)
//   motor_en    motor enable               pos_target position target
//   pos_load    1-cycle pulse, pos_target updated
//   clr_count   1-cycle pulse, clear position counter
//   resp_word   {code[7:0], payload[23:0]}, held while resp_valid is high
//   resp_valid  response pending
//   busy        command in flight (FSM not idle)
// -----------------------------------------------------------------------------
module motor_cmd_decoder #(
  parameter int SPD_W   = 16,
  parameter int POS_W   = 24,
  parameter int ERR_MAX = 255
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             cmd_done,
  input  logic [7:0]       cmd,
  input  logic [23:0]      data,
  input  logic [POS_W-1:0] pos_count,
  input  logic             resp_ready,
  output logic [SPD_W-1:0] speed_sp,
  output logic             dir,
  output logic             motor_en,
  output logic [POS_W-1:0] pos_target,
  output logic             pos_load,
  output logic             clr_count,
  output logic [31:0]      resp_word,
  output logic             resp_valid,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [7:0] CMD_NOP        = 8'h00;
  localparam logic [7:0] CMD_SET_SPEED  = 8'h01;
  localparam logic [7:0] CMD_ENABLE     = 8'h02;
  localparam logic [7:0] CMD_SET_TARGET = 8'h03;
  localparam logic [7:0] CMD_CLR_COUNT  = 8'h04;
  localparam logic [7:0] CMD_READ_POS   = 8'h05;
  localparam logic [7:0] CMD_READ_STAT  = 8'h06;

  logic [1:0]  state;
  logic        cmd_done_q;
  logic        done_d;
  logic [7:0]  cmd_q;
  logic [23:0] data_q;
  logic [7:0]  cmd_r;
  logic [23:0] data_r;
  logic [7:0]  err_cnt;
  logic        ovr;
  logic        new_frame;
  logic        frame_overrun;

  // Input capture stage: registers the frame once, so the rising edge of
  // cmd_done sampled at edge k reaches the decode two edges later.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      // Both stages reset to 1 so a cmd_done level already high when reset
      // releases is never seen as a rising edge.
      cmd_done_q <= 1'b1;
      done_d     <= 1'b1;
      cmd_q      <= '0;
      data_q     <= '0;
    end else begin
      cmd_done_q <= cmd_done;
      done_d     <= cmd_done_q;
      cmd_q      <= cmd;
      data_q     <= data;
    end
  end

  assign new_frame     = cmd_done_q & ~done_d;
  // Any non-idle cycle, including the one returning to idle, counts as busy.
  assign frame_overrun = new_frame & (state != ST_IDLE);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_r      <= '0;
      data_r     <= '0;
      speed_sp   <= '0;
      dir        <= 1'b0;
      motor_en   <= 1'b0;
      pos_target <= '0;
      pos_load   <= 1'b0;
      clr_count  <= 1'b0;
      resp_word  <= '0;
      err_cnt    <= '0;
      ovr        <= 1'b0;
    end else begin
      pos_load  <= 1'b0;
      clr_count <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (new_frame) begin
            cmd_r  <= cmd_q;
            data_r <= data_q;
            state  <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          state <= ST_IDLE;
          case (cmd_r)
            CMD_NOP: ;
            CMD_SET_SPEED: begin
              speed_sp <= data_r[SPD_W-1:0];
              dir      <= data_r[16];
            end
            CMD_ENABLE: motor_en <= data_r[0];
            CMD_SET_TARGET: begin
              pos_target <= data_r[POS_W-1:0];
              pos_load   <= 1'b1;
            end
            CMD_CLR_COUNT: clr_count <= 1'b1;
            CMD_READ_POS: begin
              resp_word <= {CMD_READ_POS, 24'(pos_count)};
              state     <= ST_RESP;
            end
            CMD_READ_STAT: begin
              resp_word <= {CMD_READ_STAT, err_cnt, 13'b0, ovr, motor_en, dir};
              ovr       <= 1'b0;
              state     <= ST_RESP;
            end
            default: begin
              if (err_cnt != 8'(ERR_MAX)) err_cnt <= err_cnt + 8'd1;
              resp_word <= {8'hFF, 16'h0000, cmd_r};
              state     <= ST_RESP;
            end
          endcase
        end

        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase

      // Placed after the READ_STAT clear so a simultaneous overrun keeps ovr set.
      if (frame_overrun) ovr <= 1'b1;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign resp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_motor_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_motor_cmd_decoder
//   Self-checking bench: a transaction-level model of the decoder is stepped
//   on every clock edge and one compare process checks all outputs against it.
//   Directed scenarios add hand-computed literal expectations; a randomized
//   phase (random commands, frame lengths, gaps, back-pressure and resets) and
//   an error-counter saturation run follow.
// -----------------------------------------------------------------------------
module tb_motor_cmd_decoder;

  logic        sys_clk;
  logic        rst;
  logic        cmd_done;
  logic [7:0]  cmd;
  logic [23:0] data;
  logic [23:0] pos_count;
  logic        resp_ready;
  logic [15:0] speed_sp;
  logic        dir;
  logic        motor_en;
  logic [23:0] pos_target;
  logic        pos_load;
  logic        clr_count;
  logic [31:0] resp_word;
  logic        resp_valid;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_mode = 0;

  motor_cmd_decoder #(.SPD_W(16), .POS_W(24), .ERR_MAX(255)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .cmd_done   (cmd_done),
    .cmd        (cmd),
    .data       (data),
    .pos_count  (pos_count),
    .resp_ready (resp_ready),
    .speed_sp   (speed_sp),
    .dir        (dir),
    .motor_en   (motor_en),
    .pos_target (pos_target),
    .pos_load   (pos_load),
    .clr_count  (clr_count),
    .resp_word  (resp_word),
    .resp_valid (resp_valid),
    .busy       (busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, transaction level: a detected frame waits one edge, is
  // either accepted (executes on the following edge) or dropped as an overrun,
  // and a read produces a response held until the handshake.
  // ---------------------------------------------------------------------------
  logic        m_cd_last;
  logic        fr_valid;
  logic [7:0]  fr_cmd;
  logic [23:0] fr_data;
  logic        m_exec;
  logic [7:0]  m_cmd;
  logic [23:0] m_data;
  logic        m_resp;
  logic [31:0] m_word;
  logic [15:0] m_speed;
  logic        m_dir;
  logic        m_en;
  logic [23:0] m_target;
  logic        m_load;
  logic        m_clr;
  int          m_err;
  logic        m_ovr;

  task automatic model_step();
    logic busy_pre;
    if (rst) begin
      m_cd_last = 1'b1; fr_valid = 1'b0; fr_cmd = '0; fr_data = '0;
      m_exec = 1'b0; m_cmd = '0; m_data = '0; m_resp = 1'b0; m_word = '0;
      m_speed = '0; m_dir = 1'b0; m_en = 1'b0; m_target = '0;
      m_load = 1'b0; m_clr = 1'b0; m_err = 0; m_ovr = 1'b0;
      return;
    end
    busy_pre = m_exec || m_resp;
    m_load = 1'b0;
    m_clr  = 1'b0;
    if (m_exec) begin
      m_exec = 1'b0;
      case (m_cmd)
        8'h00: ;
        8'h01: begin m_speed = m_data[15:0]; m_dir = m_data[16]; end
        8'h02: m_en = m_data[0];
        8'h03: begin m_target = m_data; m_load = 1'b1; end
        8'h04: m_clr = 1'b1;
        8'h05: begin m_resp = 1'b1; m_word = {8'h05, pos_count}; end
        8'h06: begin
          m_resp = 1'b1;
          m_word = {8'h06, 8'(m_err), 13'b0, m_ovr, m_en, m_dir};
          m_ovr  = 1'b0;
        end
        default: begin
          if (m_err < 255) m_err++;
          m_resp = 1'b1;
          m_word = {8'hFF, 16'h0000, m_cmd};
        end
      endcase
    end else if (m_resp && resp_ready) begin
      m_resp = 1'b0;
    end
    if (fr_valid) begin
      if (busy_pre) m_ovr = 1'b1;
      else begin m_exec = 1'b1; m_cmd = fr_cmd; m_data = fr_data; end
    end
    fr_valid  = cmd_done && !m_cd_last;
    fr_cmd    = cmd;
    fr_data   = data;
    m_cd_last = cmd_done;
  endtask

  // Single compare process: model advanced on each edge, outputs checked 1 ns later.
  always @(posedge sys_clk) begin
    model_step();
    #1;
    check("busy",       32'(busy),       32'(m_exec || m_resp));
    check("resp_valid", 32'(resp_valid), 32'(m_resp));
    if (m_resp) check("resp_word", resp_word, m_word);
    check("speed_sp",   32'(speed_sp),   32'(m_speed));
    check("dir",        32'(dir),        32'(m_dir));
    check("motor_en",   32'(motor_en),   32'(m_en));
    check("pos_target", 32'(pos_target), 32'(m_target));
    check("pos_load",   32'(pos_load),   32'(m_load));
    check("clr_count",  32'(clr_count),  32'(m_clr));
  end

  // Background randomization of back-pressure and position count.
  always @(negedge sys_clk) begin
    if (rand_mode) begin
      resp_ready = ($urandom_range(0, 2) != 0);
      pos_count  = 24'($urandom);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic frame(input logic [7:0] c, input logic [23:0] d, input int hold);
    @(negedge sys_clk);
    cmd = c; data = d; cmd_done = 1'b1;
    repeat (hold) @(negedge sys_clk);
    cmd_done = 1'b0;
    cmd = 8'($urandom); data = 24'($urandom);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic accept();
    @(negedge sys_clk); resp_ready = 1'b1;
    @(negedge sys_clk); resp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk); rst = 1'b1;
    @(negedge sys_clk); rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; cmd_done = 1'b1; cmd = 8'h01; data = 24'h01_7777;
    pos_count = 24'h00ABCD; resp_ready = 1'b0;

    // 1: reset released while cmd_done is high -> nothing executes.
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    wait_edges(5);
    check("t1_busy",  32'(busy),     32'h0);
    check("t1_speed", 32'(speed_sp), 32'h0);
    @(negedge sys_clk); cmd_done = 1'b0;
    wait_edges(2);

    // 2: SET_SPEED visible two edges after the sampled rising edge.
    frame(8'h01, 24'h01_2345, 1);
    wait_edges(1);
    check("t2_speed_early", 32'(speed_sp), 32'h0);
    wait_edges(1);
    check("t2_speed", 32'(speed_sp),   32'h2345);
    check("t2_dir",   32'(dir),        32'h1);
    check("t2_resp",  32'(resp_valid), 32'h0);
    wait_edges(2);

    // 3: SET_TARGET then CLR_COUNT, single-cycle pulses.
    frame(8'h03, 24'h00_1000, 1);
    wait_edges(2);
    check("t3_target", 32'(pos_target), 32'h001000);
    check("t3_load",   32'(pos_load),   32'h1);
    wait_edges(1);
    check("t3_load_end", 32'(pos_load), 32'h0);
    frame(8'h04, 24'h0, 1);
    wait_edges(2);
    check("t3_clr", 32'(clr_count), 32'h1);
    wait_edges(1);
    check("t3_clr_end", 32'(clr_count), 32'h0);

    // 4: READ_POS held under back-pressure, drops one cycle after ready.
    frame(8'h05, 24'h0, 1);
    wait_edges(2);
    check("t4_valid", 32'(resp_valid), 32'h1);
    check("t4_word",  resp_word,       32'h0500ABCD);
    wait_edges(5);
    check("t4_hold_valid", 32'(resp_valid), 32'h1);
    check("t4_hold_word",  resp_word,       32'h0500ABCD);
    @(negedge sys_clk); resp_ready = 1'b1;
    wait_edges(1);
    check("t4_cleared", 32'(resp_valid), 32'h0);
    @(negedge sys_clk); resp_ready = 1'b0;

    // 5: two bad commands, then status.
    for (int i = 0; i < 2; i++) begin
      frame(8'h7A, 24'h0, 1);
      wait_edges(2);
      check("t5_bad_word", resp_word, 32'hFF00007A);
      accept();
    end
    frame(8'h06, 24'h0, 1);
    wait_edges(2);
    check("t5_status", resp_word, 32'h06020001);
    accept();

    // 6: frame arriving while a response is pending is dropped, ovr sticky.
    frame(8'h05, 24'h0, 1);
    wait_edges(2);
    frame(8'h01, 24'h00_FFFF, 1);
    wait_edges(4);
    check("t6_speed_kept", 32'(speed_sp),   32'h2345);
    check("t6_still_resp", 32'(resp_valid), 32'h1);
    accept();
    frame(8'h06, 24'h0, 1);
    wait_edges(2);
    check("t6_ovr_set", resp_word, 32'h06020005);
    accept();
    frame(8'h06, 24'h0, 1);
    wait_edges(2);
    check("t6_ovr_clear", resp_word, 32'h06020001);
    accept();

    // Reset in the middle of a pending response.
    frame(8'h05, 24'h0, 1);
    wait_edges(2);
    pulse_reset();
    #2;
    check("rst_mid_valid", 32'(resp_valid), 32'h0);
    check("rst_mid_speed", 32'(speed_sp),   32'h0);

    // Randomized phase: every output checked by the compare process.
    rand_mode = 1;
    for (int it = 0; it < 300; it++) begin
      logic [7:0] c;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        7:       c = 8'($urandom);
        8:       c = 8'hC3;
        9:       c = 8'h06;
        default: c = 8'(sel);
      endcase
      frame(c, 24'($urandom), $urandom_range(1, 4));
      repeat ($urandom_range(0, 6)) @(negedge sys_clk);
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end
    @(negedge sys_clk);
    rand_mode  = 0;
    resp_ready = 1'b1;
    wait_edges(10);

    // Bad-command counter saturates at 255.
    pulse_reset();
    for (int i = 0; i < 258; i++) begin
      frame(8'h80, 24'h0, 1);
      wait_edges(3);
    end
    frame(8'h06, 24'h0, 1);
    wait_edges(2);
    check("sat_status", resp_word, 32'h06FF0000);
    wait_edges(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
